// File: rtl/nvme_ioq_pkg.sv
// Shared types and default sizes for the NVMe I/O submission-queue arbiter.
package nvme_ioq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DB   = 2'd2
  } ioq_state_t;

  localparam int DEFAULT_NUM_REQ     = 4;
  localparam int DEFAULT_QUEUE_DEPTH = 64;
  localparam int DEFAULT_DATA_WIDTH  = 256;
  localparam int QID_W               = $clog2(DEFAULT_NUM_REQ);
  localparam int TAIL_W              = $clog2(DEFAULT_QUEUE_DEPTH);

endpackage

// File: rtl/nvme_rr_arbiter.sv
// Combinational rotating-priority select starting after last_grant.
// NVME_IOQ_ADMIN_PRIO_EN: requester 0 (admin queue) wins whenever it requests.
module nvme_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int QID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [QID_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [QID_W-1:0]   gnt_idx
);

  always_comb begin
    logic             found;
    logic [QID_W-1:0] cand;
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = QID_W'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
`ifdef NVME_IOQ_ADMIN_PRIO_EN
    if (req[0]) begin
      found   = 1'b1;
      gnt_idx = '0;
    end
`endif
    if (found) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/nvme_ioq_arbiter.sv
// Shares the csr_ioq command path among submission-queue requesters, one SQE at a time,
// and rings a per-queue tail doorbell after each SQE. Option: NVME_IOQ_ADMIN_PRIO_EN.
module nvme_ioq_arbiter
  import nvme_ioq_pkg::*;
#(
  parameter int NUM_REQ     = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input  logic                             user_clk,
  input  logic                             user_reset_n,
  input  logic                             user_lnk_up,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]               req_last,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [DATA_WIDTH-1:0]            csr_ioq_data,
  output logic                             csr_ioq_valid,
  input  logic                             csr_ioq_ready,
  output logic [$clog2(NUM_REQ)-1:0]       csr_ioq_qid,
  output logic                             db_valid,
  output logic [$clog2(NUM_REQ)-1:0]       db_qid,
  output logic [$clog2(QUEUE_DEPTH)-1:0]   db_tail
);

  localparam int QW = $clog2(NUM_REQ);
  localparam int TW = $clog2(QUEUE_DEPTH);

  ioq_state_t             state_q, state_d;
  logic [QW-1:0]          grant_q, last_grant_q;
  logic [TW-1:0]          tail_q [NUM_REQ];
  logic [NUM_REQ-1:0]     arb_onehot;
  logic [QW-1:0]          arb_idx;
  logic                   arb_any;
  logic                   beat_acc, sqe_done, out_free;
  logic [DATA_WIDTH-1:0]  req_beat [NUM_REQ];
  logic [DATA_WIDTH-1:0]  out_data_p1;
  logic                   out_vld_p1;
  logic [QW-1:0]          out_qid_p1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_beat[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  nvme_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .QID_W   (QW)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx)
  );

  assign arb_any  = |arb_onehot;
  assign out_free = !out_vld_p1 || csr_ioq_ready;

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    beat_acc  = 1'b0;
    sqe_done  = 1'b0;
    db_valid  = 1'b0;
    db_qid    = '0;
    db_tail   = '0;
    case (state_q)
      IDLE: if (user_lnk_up && arb_any) state_d = XFER;
      XFER: begin
        req_ready[grant_q] = out_free;
        beat_acc           = out_free && req_valid[grant_q];
        if (beat_acc && req_last[grant_q]) begin
          sqe_done = 1'b1;
          state_d  = DB;
        end
      end
      DB: begin
        // tail_q already holds the post-increment value here
        db_valid = 1'b1;
        db_qid   = grant_q;
        db_tail  = tail_q[grant_q];
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= QW'(NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) tail_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == XFER) grant_q <= arb_idx;
      if (sqe_done) begin
        tail_q[grant_q] <= tail_q[grant_q] + 1'b1;
`ifdef NVME_IOQ_ADMIN_PRIO_EN
        // admin grants leave the rotation among the I/O queues untouched
        if (grant_q != '0) last_grant_q <= grant_q;
`else
        last_grant_q <= grant_q;
`endif
      end
    end
  end

  // Stage p1: one-entry output register toward nvme_pcie
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
      out_qid_p1  <= '0;
    end else if (beat_acc) begin
      out_vld_p1  <= 1'b1;
      out_data_p1 <= req_beat[grant_q];
      out_qid_p1  <= grant_q;
    end else if (csr_ioq_ready) begin
      out_vld_p1  <= 1'b0;
    end
  end

  assign csr_ioq_valid = out_vld_p1;
  assign csr_ioq_data  = out_data_p1;
  assign csr_ioq_qid   = out_qid_p1;

endmodule

// File: tb/tb_nvme_ioq_arbiter.sv
// Self-checking bench for nvme_ioq_arbiter: directed steps plus randomized SQE traffic
// scored against a transaction-level round-robin model.
module tb_nvme_ioq_arbiter;

  localparam int NR = 4;
  localparam int DW = 256;
  localparam int QD = 64;

  typedef struct packed { logic [DW-1:0] d; logic last; logic first; } beat_t;
  typedef struct packed { logic [DW-1:0] d; logic [1:0] qid; } obeat_t;
  typedef struct packed { logic [1:0] qid; logic [5:0] tail; } db_t;

  logic              user_clk = 1'b0;
  logic              user_reset_n;
  logic              user_lnk_up;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     csr_ioq_data;
  logic              csr_ioq_valid;
  logic              csr_ioq_ready;
  logic [1:0]        csr_ioq_qid;
  logic              db_valid;
  logic [1:0]        db_qid;
  logic [5:0]        db_tail;

  always #5 user_clk = ~user_clk;

  nvme_ioq_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) dut (
    .user_clk      (user_clk),
    .user_reset_n  (user_reset_n),
    .user_lnk_up   (user_lnk_up),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .csr_ioq_data  (csr_ioq_data),
    .csr_ioq_valid (csr_ioq_valid),
    .csr_ioq_ready (csr_ioq_ready),
    .csr_ioq_qid   (csr_ioq_qid),
    .db_valid      (db_valid),
    .db_qid        (db_qid),
    .db_tail       (db_tail)
  );

  // Source queues feeding the DUT, and the model's own copy of what is pending
  beat_t  src_q   [NR][$];
  beat_t  m_beats [NR][$];
  obeat_t exp_beats[$];
  db_t    exp_db[$];
  int     db_log[$];
  int     m_tail [NR];
  int     m_last;

  int          n_cmp, n_bad;
  bit          gap_en, rnd_rdy, prev_hold;
  int          stall_left;
  logic [DW-1:0] prev_data;
  logic [1:0]  prev_qid;
  logic [NR-1:0] last_acc;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_tail[i] = 0;
    m_last = NR - 1;
  endfunction

  // Serve every pending SQE in arbitration order: admin first (if enabled), else next after last winner
  function automatic void model_run();
    for (int guard = 0; guard < 10000; guard++) begin
      int     w;
      beat_t  b;
      obeat_t ob;
      db_t    dbe;
      w = -1;
`ifdef NVME_IOQ_ADMIN_PRIO_EN
      if (m_beats[0].size() > 0) w = 0;
`endif
      for (int k = 1; k <= NR; k++)
        if (w < 0 && m_beats[(m_last + k) % NR].size() > 0) w = (m_last + k) % NR;
      if (w < 0) break;
      do begin
        b = m_beats[w].pop_front();
        ob.d = b.d;
        ob.qid = 2'(w);
        exp_beats.push_back(ob);
      end while (!b.last);
      m_tail[w] = (m_tail[w] + 1) % QD;
      dbe.qid = 2'(w);
      dbe.tail = 6'(m_tail[w]);
      exp_db.push_back(dbe);
`ifdef NVME_IOQ_ADMIN_PRIO_EN
      if (w != 0) m_last = w;
`else
      m_last = w;
`endif
    end
  endfunction

  task automatic load_sqe(input int r, input int len);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
      b.last  = (k == len - 1);
      b.first = (k == 0);
      src_q[r].push_back(b);
      m_beats[r].push_back(b);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        req_data[i*DW +: DW] = src_q[i][0].d;
        req_last[i]  = src_q[i][0].last;
        req_valid[i] = src_q[i][0].first || !gap_en || ($urandom_range(0, 3) != 0);
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
    if (stall_left > 0) begin
      csr_ioq_ready = 1'b0;
      stall_left--;
    end else begin
      csr_ioq_ready = !rnd_rdy || ($urandom_range(0, 3) != 0);
    end
  endtask

  // Called mid-cycle with inputs settled: check outputs, cross one clock edge, update sources
  task automatic tick();
    last_acc = req_valid & req_ready;
    check("rdy_onehot", 256'($countones(req_ready) <= 1), 256'(1));
    if (csr_ioq_valid && !csr_ioq_ready) check("stall_rdy", 256'(req_ready), 256'(0));
    if (prev_hold) begin
      check("hold_data", csr_ioq_data, prev_data);
      check("hold_qid", 256'(csr_ioq_qid), 256'(prev_qid));
    end
    if (csr_ioq_valid && csr_ioq_ready) begin
      if (exp_beats.size() == 0) check("extra_beat", 256'(csr_ioq_qid), 256'(NR));
      else begin
        obeat_t e;
        e = exp_beats.pop_front();
        check("beat_data", csr_ioq_data, e.d);
        check("beat_qid", 256'(csr_ioq_qid), 256'(e.qid));
      end
    end
    if (db_valid) begin
      db_log.push_back(int'(db_qid));
      if (exp_db.size() == 0) check("extra_db", 256'(db_qid), 256'(NR));
      else begin
        db_t e;
        e = exp_db.pop_front();
        check("db_qid", 256'(db_qid), 256'(e.qid));
        check("db_tail", 256'(db_tail), 256'(e.tail));
      end
    end
    prev_hold = csr_ioq_valid && !csr_ioq_ready;
    prev_data = csr_ioq_data;
    prev_qid  = csr_ioq_qid;
    @(posedge user_clk);
    @(negedge user_clk);
    for (int i = 0; i < NR; i++) if (last_acc[i] && src_q[i].size() > 0) src_q[i].delete(0);
    drive();
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pending() || exp_beats.size() > 0 || exp_db.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 256'(n < budget), 256'(1));
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},  256'(req_ready),     256'(0));
    check({tag, "_ov"},   256'(csr_ioq_valid), 256'(0));
    check({tag, "_od"},   csr_ioq_data,        256'(0));
    check({tag, "_oq"},   256'(csr_ioq_qid),   256'(0));
    check({tag, "_dbv"},  256'(db_valid),      256'(0));
    check({tag, "_dbq"},  256'(db_qid),        256'(0));
    check({tag, "_dbt"},  256'(db_tail),       256'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] da, dbb;
    int exp_ord[5];
    int exp_adm[2];
    int n;
    bit any;
    n_cmp = 0; n_bad = 0;
    gap_en = 0; rnd_rdy = 0; stall_left = 0; prev_hold = 0;
    prev_data = '0; prev_qid = '0; last_acc = '0;
    req_valid = '0; req_data = '0; req_last = '0;
    csr_ioq_ready = 1'b1; user_lnk_up = 1'b1; user_reset_n = 1'b0;
    model_reset();
    for (int w = 0; w < DW / 32; w++) begin
      da[w*32 +: 32]  = $urandom;
      dbb[w*32 +: 32] = $urandom;
    end

    // Reset values
    repeat (3) @(negedge user_clk);
    #1;
    check_reset_outputs("rst");

    // Requester 2 alone, 2-beat SQE, cycle-exact timing
    @(negedge user_clk);
    user_reset_n = 1'b1;
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = da;
    #1;
    check("t1_c0_rdy", 256'(req_ready), 256'(0));
    @(posedge user_clk); @(negedge user_clk); #1;
    check("t1_c1_rdy", 256'(req_ready), 256'(4'b0100));
    check("t1_c1_ov", 256'(csr_ioq_valid), 256'(0));
    @(posedge user_clk); @(negedge user_clk);
    #1;
    check("t1_c2_ov", 256'(csr_ioq_valid), 256'(1));
    check("t1_c2_od", csr_ioq_data, da);
    check("t1_c2_oq", 256'(csr_ioq_qid), 256'(2));
    check("t1_c2_dbv", 256'(db_valid), 256'(0));
    check("t1_c2_rdy", 256'(req_ready), 256'(4'b0100));
    req_data[2*DW +: DW] = dbb;
    req_last = 4'b0100;
    @(posedge user_clk); @(negedge user_clk);
    req_valid = '0; req_last = '0;
    #1;
    check("t1_c3_ov", 256'(csr_ioq_valid), 256'(1));
    check("t1_c3_od", csr_ioq_data, dbb);
    check("t1_c3_oq", 256'(csr_ioq_qid), 256'(2));
    check("t1_c3_dbv", 256'(db_valid), 256'(1));
    check("t1_c3_dbq", 256'(db_qid), 256'(2));
    check("t1_c3_dbt", 256'(db_tail), 256'(1));
    check("t1_c3_rdy", 256'(req_ready), 256'(0));
    @(posedge user_clk); @(negedge user_clk); #1;
    check("t1_c4_dbv", 256'(db_valid), 256'(0));
    check("t1_c4_ov", 256'(csr_ioq_valid), 256'(0));
    m_tail[2] = 1;
    m_last = 2;

    // Requester 1: 65 single-beat SQEs, tail wraps 63 -> 0
    rnd_rdy = 1;
    for (int k = 0; k < 65; k++) load_sqe(1, 1);
    model_run();
    drive(); #1;
    drain(2000);

    // Downstream stall of 5 cycles in the middle of a 4-beat SQE
    rnd_rdy = 0;
    load_sqe(0, 4);
    model_run();
    drive(); #1;
    n = 0;
    while (!csr_ioq_valid && n < 20) begin tick(); n++; end
    check("stall_wait_ov", 256'(csr_ioq_valid), 256'(1));
    stall_left = 5;
    drain(100);

    // Link drops during beat 1 of a requester-3 SQE
    load_sqe(3, 3);
    model_run();
    drive(); #1;
    n = 0;
    last_acc = '0;
    while (!last_acc[3] && n < 20) begin tick(); n++; end
    check("lnk_first_acc", 256'(last_acc[3]), 256'(1));
    user_lnk_up = 1'b0;
    load_sqe(0, 2);
    drive(); #1;
    n = 0;
    while (exp_db.size() > 0 && n < 30) begin tick(); n++; end
    check("lnk_db_seen", 256'(exp_db.size()), 256'(0));
    for (int k = 0; k < 8; k++) begin
      check("lnk_no_grant", 256'(req_ready), 256'(0));
      tick();
    end
    user_lnk_up = 1'b1;
    model_run();
    drain(200);

    // Reset in the middle of traffic
    gap_en = 1; rnd_rdy = 1;
    for (int r = 0; r < NR; r++) begin
      load_sqe(r, $urandom_range(1, 4));
      load_sqe(r, $urandom_range(1, 4));
    end
    model_run();
    drive(); #1;
    repeat (6) tick();
    user_reset_n = 1'b0;
    @(posedge user_clk); @(negedge user_clk); #1;
    check_reset_outputs("mid_rst");
    for (int r = 0; r < NR; r++) begin
      src_q[r].delete();
      m_beats[r].delete();
    end
    exp_beats.delete();
    exp_db.delete();
    model_reset();
    prev_hold = 0;
    @(negedge user_clk);
    user_reset_n = 1'b1;
    drive(); #1;

    // All requesters continuously busy with 2-beat SQEs
    gap_en = 0; rnd_rdy = 0;
    db_log.delete();
    for (int r = 0; r < NR; r++) begin
      load_sqe(r, 2);
      load_sqe(r, 2);
    end
    model_run();
    drive(); #1;
    drain(200);
`ifdef NVME_IOQ_ADMIN_PRIO_EN
    exp_ord = '{0, 0, 1, 2, 3};
`else
    exp_ord = '{0, 1, 2, 3, 0};
`endif
    check("t2_cnt", 256'(db_log.size()), 256'(8));
    for (int k = 0; k < 5; k++) check("t2_order", 256'(db_log[k]), 256'(exp_ord[k]));

    // Grant to 1, then 0 and 2 request together
    db_log.delete();
    load_sqe(1, 2);
    model_run();
    drive(); #1;
    drain(100);
    load_sqe(0, 2);
    load_sqe(2, 2);
    model_run();
    drive(); #1;
    drain(100);
`ifdef NVME_IOQ_ADMIN_PRIO_EN
    exp_adm = '{0, 2};
`else
    exp_adm = '{2, 0};
`endif
    check("t6_cnt", 256'(db_log.size()), 256'(3));
    for (int k = 0; k < 2; k++) check("t6_order", 256'(db_log[k + 1]), 256'(exp_adm[k]));

    // Randomized traffic with valid gaps and random backpressure
    gap_en = 1; rnd_rdy = 1;
    for (int round = 0; round < 8; round++) begin
      any = 1'b0;
      for (int r = 0; r < NR; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          any = 1'b1;
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) load_sqe(r, $urandom_range(1, 4));
        end
      end
      if (!any) load_sqe($urandom_range(0, NR - 1), $urandom_range(1, 4));
      model_run();
      drive(); #1;
      drain(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nvme_ioq_arbiter.md
# nvme_ioq_arbiter

Round-robin scheduler that shares the single 256-bit `csr_ioq_data`/`csr_ioq_valid` command path into `nvme_pcie` among several submission-queue requesters. It grants one requester per NVMe submission queue entry (SQE), forwards its beats through a one-entry output register with backpressure, and tracks a per-queue tail pointer. When an SQE completes it emits a doorbell update. It sits between the `csr` command generators and the root-port `nvme_pcie` block, in the `user_clk` domain.

## Interface
- `NUM_REQ`, 4: number of requesters (one submission queue each); must be at least 2.
- `DATA_WIDTH`, 256: beat width; matches `csr_ioq_data`.
- `QUEUE_DEPTH`, 64: entries per submission queue; must be a power of two, at least 2.
- `user_clk`  in  1  Sole clock, the PCIe user clock.
- `user_reset_n`  in  1  Reset; synchronous, active-low.
- `user_lnk_up`  in  1  When low, no new grant is issued.
- `req_valid`  in  `NUM_REQ`  Per-requester beat valid.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  Per-requester beat data; requester i occupies slice [i*W +: W].
- `req_last`  in  `NUM_REQ`  Marks the final beat of an SQE.
- `req_ready`  out  `NUM_REQ`  Per-requester beat accept.
- `csr_ioq_data`  out  `DATA_WIDTH`  Forwarded beat.
- `csr_ioq_valid`  out  1  Output beat valid.
- `csr_ioq_ready`  in  1  Downstream accept.
- `csr_ioq_qid`  out  `clog2(NUM_REQ)`  Source queue of the current output beat.
- `db_valid`  out  1  One-cycle doorbell pulse.
- `db_qid`  out  `clog2(NUM_REQ)`  Queue being rung.
- `db_tail`  out  `clog2(QUEUE_DEPTH)`  New tail value.

## Operation
- FSM with three states: IDLE, XFER, DB.
- **IDLE**
  - If `user_lnk_up` is high and any `req_valid` is high, select a winner by rotating priority starting at `last_grant+1` (mod `NUM_REQ`).
  - Register the winner into `grant` and go to XFER.
  - All `req_ready` are low in IDLE.
- **XFER**
  - `req_ready[grant]` = !`csr_ioq_valid` || `csr_ioq_ready`; all other `req_ready` bits are 0.
  - An accepted beat loads `csr_ioq_data`, sets `csr_ioq_valid` and sets `csr_ioq_qid` = `grant`.
  - An accepted beat with `req_last` high:
    - `tail[grant]` ← (`tail[grant]` + 1) mod `QUEUE_DEPTH`.
    - `last_grant` ← `grant`.
    - Go to DB.
- **DB**
  - `db_valid` = 1 for exactly one cycle, with `db_qid` = `grant` and `db_tail` = the updated tail.
  - Then return to IDLE.
- Output register: `csr_ioq_valid` clears on `csr_ioq_ready` unless a new beat is loaded in the same cycle. `csr_ioq_data` holds its value while valid and not ready.
- SQE length is arbitrary, one or more beats. The grant is held until `req_last`; beats are never interleaved across queues.
- `user_lnk_up` falling during XFER: the current SQE completes normally. IDLE then issues no new grant until the link returns.
- `req_valid[grant]` dropping mid-SQE: hold in XFER and wait, with no timeout.
- Tail wraps from `QUEUE_DEPTH-1` to 0. Queue-full detection is the host's responsibility and is not checked here.
- Reset, including mid-operation:
  - State returns to IDLE.
  - All tails go to 0 and `last_grant` goes to `NUM_REQ-1`, so requester 0 has first priority.
  - `csr_ioq_valid` and any in-flight beat are dropped.

## Timing
- Reset values: `req_ready` = 0, `csr_ioq_valid` = 0, `csr_ioq_data` = 0, `csr_ioq_qid` = 0, `db_valid` = 0, `db_qid` = 0, `db_tail` = 0.
- `req_valid` is sampled in IDLE at cycle 0. `req_ready` rises at cycle 1, and the first `csr_ioq_valid` appears at cycle 2.
- The doorbell fires the cycle after the last beat is accepted, and the FSM is back in IDLE the cycle after that.
- With no backpressure, a 2-beat SQE occupies 4 cycles (IDLE, XFER ×2, DB).
- `db_valid` and `csr_ioq_valid` can be high together: the last beat is still in the output register while DB asserts.
- Output register latency is 1 cycle. Full throughput within an SQE is 1 beat per cycle when `csr_ioq_ready` is held high.

## Configuration
- `NVME_IOQ_ADMIN_PRIO_EN`
  - **Defined:** requester 0 (the admin queue) wins in IDLE whenever `req_valid[0]` is high, overriding rotation. Rotation among requesters 1..`NUM_REQ-1` is unchanged, and `last_grant` is not updated by an admin grant.
  - **Undefined:** pure round-robin across all requesters.

## Structure
- Package `nvme_ioq_pkg` contains:
  - the state enum (IDLE, XFER, DB);
  - localparams `QID_W` = clog2(`NUM_REQ`) and `TAIL_W` = clog2(`QUEUE_DEPTH`);
  - the default `DATA_WIDTH` (256).
- Sub-module `nvme_rr_arbiter`: combinational rotating-priority select (request vector, `last_grant`) → one-hot grant and encoded index, with the admin override under the macro. The FSM, tails and output register live in `nvme_ioq_arbiter`.

## Test plan
- Reset is released with `user_lnk_up` = 1 and only requester 2 presents a 2-beat SQE (A, B) → `csr_ioq` carries A then B with qid 2, and `db_valid` pulses once with qid 2, tail 1.
- All 4 requesters continuously present 2-beat SQEs → grant order 0, 1, 2, 3, 0, and each tail increments by 1 per SQE.
- Requester 1 submits 65 SQEs with `QUEUE_DEPTH` = 64 → `db_tail` sequence is 1..63, 0, 1.
- `csr_ioq_ready` is held low for 5 cycles mid-SQE → `csr_ioq_data` stays stable, `req_ready` stays 0, and no beat is lost or duplicated.
- `user_lnk_up` drops during beat 1 of a requester-3 SQE → the SQE completes and its doorbell fires, and no new grant occurs until `user_lnk_up` = 1.
- With the macro defined, requesters 0 and 2 are both valid after a grant to 1 → requester 0 is granted first, then 2.
